// File: rtl/cmac_feeder.sv
// cmac_feeder: operand sequencer and result collector for one cmac FP16 MAC.
//
// Accepts one dot-product command and streams N operand pairs from the data
// and weight buffers into cmac. Each pair is held until cmac pulses
// cmac_rdy_acc. When cmac raises cmac_conv_valid, the result is written to
// the output buffer and cmac is cleared for the next job.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, data_base, weight_base,  command strobe and fields, latched on an
//   out_addr, op_count              accepted start (ignored while busy)
//   busy, done                      job status / one-cycle completion pulse
//   data_addr/data_rd_en/data_q     data buffer read port (1-cycle latency)
//   weight_addr/weight_rd_en/       weight buffer read port (1-cycle latency)
//   weight_q
//   out_wr_addr/out_wr_data/        output buffer write port
//   out_wr_en
//   cmac_rst, cmac_conv_ready,      cmac control: reset, launch strobe, N-1
//   cmac_op_num
//   cmac_data, cmac_weight          current operand pair
//   cmac_rdy_acc, cmac_conv_valid,  cmac status and final (clamped) sum
//   cmac_result
module cmac_feeder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] data_base,
    input  logic [ADDR_W-1:0] weight_base,
    input  logic [ADDR_W-1:0] out_addr,
    input  logic [31:0]       op_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_rd_en,
    input  logic [15:0]       data_q,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              weight_rd_en,
    input  logic [15:0]       weight_q,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [15:0]       out_wr_data,
    output logic              out_wr_en,
    output logic              cmac_rst,
    output logic              cmac_conv_ready,
    output logic [31:0]       cmac_op_num,
    output logic [15:0]       cmac_data,
    output logic [15:0]       cmac_weight,
    input  logic              cmac_rdy_acc,
    input  logic              cmac_conv_valid,
    input  logic [15:0]       cmac_result
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, PRE0, PRE1, LAUNCH, RUN, WAITV, WRITE, DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] data_base_q, weight_base_q, out_addr_q;
    logic [31:0]       n_q;
    logic [31:0]       k_q;
    logic [15:0]       shadow_data_q, shadow_weight_q;
    logic              rd_pend_q;
    logic              busy_q, done_q, out_wr_en_q, cmac_rst_q, conv_ready_q;
    logic [ADDR_W-1:0] out_wr_addr_q;
    logic [15:0]       out_wr_data_q, op_data_q, op_weight_q;
    logic [31:0]       op_num_q;

    // Read issue is combinational on cmac_rdy_acc: issuing in the same cycle
    // as the advance lets the reply reach the shadow registers before the
    // earliest possible next cmac_rdy_acc (pulses are >= 2 cycles apart).
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_off;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_issue = 1'b0;
        rd_off   = '0;
        unique case (state_q)
            PRE0: rd_issue = 1'b1;
            PRE1: begin
                rd_issue = (n_q >= 32'd2);
                rd_off   = ADDR_W'(1);
            end
            RUN: begin
                // 33-bit compare so k+2 cannot wrap for huge N.
                rd_issue = cmac_rdy_acc && (({1'b0, k_q} + 33'd2) < {1'b0, n_q});
                rd_off   = k_q[ADDR_W-1:0] + ADDR_W'(2);
            end
            default: ;
        endcase
    end

    // Addresses are forced to zero when no read is issued; wrap is silent.
    assign data_rd_en   = rd_issue;
    assign weight_rd_en = rd_issue;
    assign data_addr    = rd_issue ? data_base_q + rd_off : '0;
    assign weight_addr  = rd_issue ? weight_base_q + rd_off : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the value from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            data_base_q     <= '0;
            weight_base_q   <= '0;
            out_addr_q      <= '0;
            n_q             <= '0;
            k_q             <= '0;
            shadow_data_q   <= '0;
            shadow_weight_q <= '0;
            rd_pend_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            out_wr_en_q     <= 1'b0;
            out_wr_addr_q   <= '0;
            out_wr_data_q   <= '0;
            cmac_rst_q      <= 1'b1;   // hold cmac in reset alongside us
            conv_ready_q    <= 1'b0;
            op_num_q        <= '0;
            op_data_q       <= '0;
            op_weight_q     <= '0;
        end else begin
            // Single-cycle strobes default low each cycle.
            done_q       <= 1'b0;
            out_wr_en_q  <= 1'b0;
            cmac_rst_q   <= 1'b0;
            conv_ready_q <= 1'b0;

            // A reply always lands one cycle after its read; PRE1 consumes
            // the index-0 reply directly, every other reply goes to shadow.
            rd_pend_q <= rd_issue;
            if (rd_pend_q && state_q != PRE1) begin
                shadow_data_q   <= data_q;
                shadow_weight_q <= weight_q;
            end

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        data_base_q   <= data_base;
                        weight_base_q <= weight_base;
                        out_addr_q    <= out_addr;
                        n_q           <= op_count;
                        k_q           <= '0;
                        busy_q        <= 1'b1;
                        if (op_count == 32'd0) begin
                            // Empty dot product: write zero without touching cmac.
                            state_q       <= WRITE;
                            out_wr_en_q   <= 1'b1;
                            out_wr_addr_q <= out_addr;
                            out_wr_data_q <= 16'h0000;
                        end else begin
                            state_q    <= CLEAR;
                            cmac_rst_q <= 1'b1;
                        end
                    end
                end
                CLEAR: state_q <= PRE0;
                PRE0:  state_q <= PRE1;
                PRE1: begin
                    op_data_q    <= data_q;
                    op_weight_q  <= weight_q;
                    conv_ready_q <= 1'b1;
                    op_num_q     <= n_q - 32'd1;
                    state_q      <= LAUNCH;
                end
                LAUNCH: state_q <= RUN;
                RUN: begin
                    if (cmac_rdy_acc) begin
                        if (k_q != n_q - 32'd1) begin
                            op_data_q   <= shadow_data_q;
                            op_weight_q <= shadow_weight_q;
                            k_q         <= k_q + 32'd1;
                        end else begin
                            state_q <= WAITV;
                        end
                    end
                end
                WAITV: begin
                    if (cmac_conv_valid) begin
                        state_q       <= WRITE;
                        out_wr_en_q   <= 1'b1;
                        out_wr_addr_q <= out_addr_q;
                        out_wr_data_q <= cmac_result;
                    end
                end
                WRITE: begin
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    cmac_rst_q <= 1'b1;   // pull cmac out of its finish state
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign out_wr_en       = out_wr_en_q;
    assign out_wr_addr     = out_wr_addr_q;
    assign out_wr_data     = out_wr_data_q;
    assign cmac_rst        = cmac_rst_q;
    assign cmac_conv_ready = conv_ready_q;
    assign cmac_op_num     = op_num_q;
    assign cmac_data       = op_data_q;
    assign cmac_weight     = op_weight_q;

endmodule

// File: tb/tb_cmac_feeder.sv
// Self-checking bench for cmac_feeder. Buffers are modelled as 1-cycle
// synchronous-read arrays filled with FP16 encodings of small integers, so a
// plain integer dot product gives the exact expected FP16 result. A
// behavioural cmac consumes the operand pairs with random multiply delays.
module tb_cmac_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] data_base, weight_base, out_addr;
    logic [31:0] op_count;
    logic        busy, done;
    logic [15:0] data_addr, weight_addr;
    logic        data_rd_en, weight_rd_en;
    logic [15:0] data_q, weight_q;
    logic [15:0] out_wr_addr, out_wr_data;
    logic        out_wr_en;
    logic        cmac_rst, cmac_conv_ready;
    logic [31:0] cmac_op_num;
    logic [15:0] cmac_data, cmac_weight;
    logic        cmac_rdy_acc = 1'b0;
    logic        cmac_conv_valid = 1'b0;
    logic [15:0] cmac_result = 16'h0;

    int vectors = 0;
    int miscompares = 0;

    cmac_feeder #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .data_base(data_base), .weight_base(weight_base), .out_addr(out_addr),
        .op_count(op_count), .busy(busy), .done(done),
        .data_addr(data_addr), .data_rd_en(data_rd_en), .data_q(data_q),
        .weight_addr(weight_addr), .weight_rd_en(weight_rd_en), .weight_q(weight_q),
        .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data), .out_wr_en(out_wr_en),
        .cmac_rst(cmac_rst), .cmac_conv_ready(cmac_conv_ready), .cmac_op_num(cmac_op_num),
        .cmac_data(cmac_data), .cmac_weight(cmac_weight),
        .cmac_rdy_acc(cmac_rdy_acc), .cmac_conv_valid(cmac_conv_valid),
        .cmac_result(cmac_result)
    );

    always #5 clk = ~clk;

    // FP16 encode of a non-negative integer (exact up to 2047).
    function automatic logic [15:0] enc(input int v);
        int e;
        if (v <= 0) return 16'h0000;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return 16'((e + 15) << 10) | 16'((v << (10 - e)) & 'h3FF);
    endfunction

    // FP16 decode to integer (fractions truncate).
    function automatic int dec(input logic [15:0] h);
        int e, m;
        if (h[14:0] == 15'd0) return 0;
        e = int'(h[14:10]) - 15;
        m = int'(h[9:0]) | 'h400;
        if (e < 0) return 0;
        if (e > 10) return m << (e - 10);
        return m >> (10 - e);
    endfunction

    logic [15:0] dmem [65536];
    logic [15:0] wmem [65536];

    always @(posedge clk) begin
        if (data_rd_en)   data_q   <= dmem[data_addr];
        if (weight_rd_en) weight_q <= wmem[weight_addr];
    end

    // Behavioural cmac: after launch, takes N pairs, each finished by a
    // rdy_acc pulse after 1..3 idle cycles, then raises conv_valid.
    logic [31:0] seen_log [$];
    int m_phase = 0, m_left = 0, m_wait = 0, m_acc = 0;

    always @(posedge clk) begin
        cmac_rdy_acc <= 1'b0;
        if (cmac_rst) begin
            m_phase         <= 0;
            m_acc           <= 0;
            cmac_conv_valid <= 1'b0;
            cmac_result     <= 16'h0;
        end else begin
            if (cmac_rdy_acc) begin
                seen_log.push_back({cmac_data, cmac_weight});
                m_acc <= m_acc + dec(cmac_data) * dec(cmac_weight);
            end
            case (m_phase)
                0: if (cmac_conv_ready) begin
                    m_phase <= 1;
                    m_left  <= int'(cmac_op_num) + 1;
                    m_wait  <= int'($urandom_range(1, 3));
                end
                1: if (m_wait > 0) m_wait <= m_wait - 1;
                   else begin
                       cmac_rdy_acc <= 1'b1;
                       m_wait       <= int'($urandom_range(1, 3));
                       if (m_left == 1) m_phase <= 2;
                       m_left <= m_left - 1;
                   end
                2: if (m_wait > 0) m_wait <= m_wait - 1;
                   else if (!cmac_conv_valid) begin
                       cmac_conv_valid <= 1'b1;
                       cmac_result     <= enc(m_acc);
                   end
                default: m_phase <= 0;
            endcase
        end
    end

    // Passive monitor of the DUT's buffer ports and strobes.
    logic [15:0] rd_d_log [$];
    logic [15:0] rd_w_log [$];
    logic [31:0] wr_log [$];
    int cyc = 0, done_cnt = 0, launch_cnt = 0, en_bad = 0, rst_pulse = 0;
    int wr_cyc = 0, done_cyc = 0, launch_cyc = 0, cv_cyc = 0;
    logic [31:0] op_num_seen = 32'h0;
    logic cv_prev = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        cv_prev <= cmac_conv_valid;
        if (rst_n) begin
            if (data_rd_en)   rd_d_log.push_back(data_addr);
            if (weight_rd_en) rd_w_log.push_back(weight_addr);
            if (data_rd_en !== weight_rd_en) en_bad <= en_bad + 1;
            if (out_wr_en) begin
                wr_log.push_back({out_wr_addr, out_wr_data});
                wr_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (cmac_conv_ready) begin
                launch_cnt  <= launch_cnt + 1;
                launch_cyc  <= cyc;
                op_num_seen <= cmac_op_num;
            end
            if (cmac_conv_valid && !cv_prev) cv_cyc <= cyc;
            if (cmac_rst) rst_pulse <= rst_pulse + 1;
        end
    end

    // One full job: drive start, wait for done, compare everything observed
    // against the dot product computed from the buffer arrays.
    task automatic do_job(input logic [15:0] db, input logic [15:0] wb,
                          input logic [15:0] oa, input int n, input bit poke);
        int rd0, rw0, wr0, sn0, dn0, ln0, rp0, eb0, c0, sum;
        logic [15:0] exp_res, a, b;
        bit got, poked;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            a = db + 16'(i);
            b = wb + 16'(i);
            sum += dec(dmem[a]) * dec(wmem[b]);
        end
        exp_res = enc(sum);

        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
        rd0 = rd_d_log.size(); rw0 = rd_w_log.size(); wr0 = wr_log.size();
        sn0 = seen_log.size(); dn0 = done_cnt; ln0 = launch_cnt;
        rp0 = rst_pulse; eb0 = en_bad; c0 = cyc;
        start = 1'b1; data_base = db; weight_base = wb; out_addr = oa; op_count = n;
        @(negedge clk);
        // Scramble the fields: the job must run on the latched copies.
        start = 1'b0; data_base = 16'($urandom); weight_base = 16'($urandom);
        out_addr = 16'($urandom); op_count = $urandom;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL accept_busy: got %b want 1", busy); end
        if (n > 0) begin
            vectors++;
            if (cmac_rst !== 1'b1) begin miscompares++; $display("FAIL clear_pulse: got %b want 1", cmac_rst); end
        end else begin
            vectors++;
            if ({out_wr_en, out_wr_data} !== 17'h10000) begin
                miscompares++; $display("FAIL n0_write: got en=%b data=%h want en=1 data=0000", out_wr_en, out_wr_data);
            end
        end

        got = 0; poked = 0;
        for (int t = 0; t < 1000 && !got; t++) begin
            if (done === 1'b1) got = 1;
            else begin
                if (poke && !poked && launch_cnt != ln0) begin
                    start = 1'b1; data_base = 16'($urandom); weight_base = 16'($urandom);
                    out_addr = 16'($urandom); op_count = 32'd3; poked = 1;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL done_timeout: no done within 1000 cycles, N=%0d", n); return; end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_at_done: got %b want 1", busy); end
        @(posedge clk); #1;

        vectors++;
        if (done_cnt - dn0 != 1) begin miscompares++; $display("FAIL done_count: got %0d want 1", done_cnt - dn0); end
        vectors++;
        if (wr_log.size() - wr0 != 1) begin
            miscompares++; $display("FAIL write_count: got %0d want 1", wr_log.size() - wr0);
        end else begin
            vectors++;
            if (wr_log[wr0] !== {oa, exp_res}) begin
                miscompares++; $display("FAIL write: got %h want %h (N=%0d)", wr_log[wr0], {oa, exp_res}, n);
            end
        end
        vectors++;
        if (rd_d_log.size() - rd0 != n || rd_w_log.size() - rw0 != n) begin
            miscompares++; $display("FAIL read_count: got %0d/%0d want %0d", rd_d_log.size() - rd0, rd_w_log.size() - rw0, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (rd_d_log[rd0 + i] !== db + 16'(i) || rd_w_log[rw0 + i] !== wb + 16'(i)) begin
                    miscompares++; $display("FAIL read_addr[%0d]: got %h/%h want %h/%h", i,
                        rd_d_log[rd0 + i], rd_w_log[rw0 + i], db + 16'(i), wb + 16'(i));
                end
            end
        end
        vectors++;
        if (seen_log.size() - sn0 != n) begin
            miscompares++; $display("FAIL operand_count: got %0d want %0d", seen_log.size() - sn0, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                a = db + 16'(i); b = wb + 16'(i);
                vectors++;
                if (seen_log[sn0 + i] !== {dmem[a], wmem[b]}) begin
                    miscompares++; $display("FAIL operand[%0d]: got %h want %h", i, seen_log[sn0 + i], {dmem[a], wmem[b]});
                end
            end
        end
        vectors++;
        if (launch_cnt - ln0 != (n > 0 ? 1 : 0)) begin
            miscompares++; $display("FAIL launch_count: got %0d want %0d", launch_cnt - ln0, (n > 0 ? 1 : 0));
        end
        vectors++;
        if (rst_pulse - rp0 != (n > 0 ? 2 : 1)) begin
            miscompares++; $display("FAIL cmac_rst_cycles: got %0d want %0d", rst_pulse - rp0, (n > 0 ? 2 : 1));
        end
        vectors++;
        if (en_bad != eb0) begin miscompares++; $display("FAIL rd_en_pair: got %0d splits want 0", en_bad - eb0); end
        if (n > 0) begin
            vectors++;
            if (op_num_seen !== 32'(n - 1)) begin miscompares++; $display("FAIL op_num: got %0d want %0d", op_num_seen, n - 1); end
            vectors++;
            if (launch_cyc - c0 != 4) begin miscompares++; $display("FAIL launch_time: got %0d want 4", launch_cyc - c0); end
            vectors++;
            if (wr_cyc != cv_cyc + 1) begin miscompares++; $display("FAIL write_time: got %0d want %0d", wr_cyc, cv_cyc + 1); end
        end else begin
            vectors++;
            if (wr_cyc - c0 != 1) begin miscompares++; $display("FAIL n0_write_time: got %0d want 1", wr_cyc - c0); end
        end
        vectors++;
        if (done_cyc != wr_cyc + 1) begin miscompares++; $display("FAIL done_time: got %0d want %0d", done_cyc, wr_cyc + 1); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, data_addr, data_rd_en, weight_addr, weight_rd_en, out_wr_addr, out_wr_data,
             out_wr_en, cmac_conv_ready, cmac_op_num, cmac_data, cmac_weight} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        vectors++;
        if (cmac_rst !== 1'b1) begin miscompares++; $display("FAIL reset_cmac_rst: got %b want 1", cmac_rst); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cmac_rst, busy} !== 2'b00) begin miscompares++; $display("FAIL after_reset: got rst=%b busy=%b want 0 0", cmac_rst, busy); end
    endtask

    task automatic test_n1();
        dmem[16'h0100] = 16'h4000;
        wmem[16'h0200] = 16'h4200;
        do_job(16'h0100, 16'h0200, 16'h0030, 1, 1'b0);
        vectors++;
        if (wr_log[$] !== {16'h0030, 16'h4600}) begin miscompares++; $display("FAIL n1_result: got %h want 00304600", wr_log[$]); end
    endtask

    task automatic test_n4();
        logic [15:0] d [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        for (int i = 0; i < 4; i++) begin
            dmem[16'h1000 + i] = d[i];
            wmem[16'h2000 + i] = 16'h3C00;
        end
        do_job(16'h1000, 16'h2000, 16'h0040, 4, 1'b0);
        vectors++;
        if (wr_log[$] !== {16'h0040, 16'h4900}) begin miscompares++; $display("FAIL n4_result: got %h want 00404900", wr_log[$]); end
    endtask

    task automatic test_n0();
        do_job(16'h1234, 16'h5678, 16'h0050, 0, 1'b0);
    endtask

    task automatic test_wrap();
        int r0;
        logic [15:0] want [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        r0 = rd_d_log.size();
        do_job(16'hFFFE, 16'h3000, 16'h0060, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rd_d_log.size() <= r0 + i || rd_d_log[r0 + i] !== want[i]) begin
                miscompares++; $display("FAIL wrap_addr[%0d]: want %h", i, want[i]);
            end
        end
    endtask

    task automatic test_busy_start();
        do_job(16'h4000, 16'h5000, 16'h0070, 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_job(16'h6000, 16'h6100, 16'h0080, 2, 1'b0);
        do_job(16'h6200, 16'h6300, 16'h0081, 3, 1'b0);
    endtask

    task automatic test_reset_mid_job();
        int wr0, dn0, ln0;
        bit seen;
        @(negedge clk);
        wr0 = wr_log.size(); dn0 = done_cnt; ln0 = launch_cnt;
        start = 1'b1; data_base = 16'h0400; weight_base = 16'h0500; out_addr = 16'h0090; op_count = 32'd6;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (launch_cnt != ln0) seen = 1;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (!seen || busy !== 1'b1) begin miscompares++; $display("FAIL midjob_running: launch=%0b busy=%b want 1 1", seen, busy); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, data_addr, data_rd_en, weight_addr, weight_rd_en, out_wr_addr, out_wr_data,
             out_wr_en, cmac_conv_ready, cmac_op_num, cmac_data, cmac_weight} !== '0) begin
            miscompares++; $display("FAIL midjob_outputs: got nonzero outputs, want all 0");
        end
        vectors++;
        if (cmac_rst !== 1'b1) begin miscompares++; $display("FAIL midjob_cmac_rst: got %b want 1", cmac_rst); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (wr_log.size() != wr0 || done_cnt != dn0) begin
            miscompares++; $display("FAIL midjob_abort: got writes=%0d dones=%0d want 0 0", wr_log.size() - wr0, done_cnt - dn0);
        end
        vectors++;
        if ({busy, cmac_rst} !== 2'b00) begin miscompares++; $display("FAIL midjob_idle: got busy=%b rst=%b want 0 0", busy, cmac_rst); end
        do_job(16'h0700, 16'h0800, 16'h0091, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++)
            do_job(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 8)), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        data_base = '0; weight_base = '0; out_addr = '0; op_count = '0;
        for (int i = 0; i < 65536; i++) begin
            dmem[i] = enc(int'($urandom_range(0, 7)));
            wmem[i] = enc(int'($urandom_range(0, 3)));
        end
        test_reset();
        test_n1();
        test_n4();
        test_n0();
        test_wrap();
        test_busy_start();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
